// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and sizing helper for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1, but never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell: sum and carry of two inputs.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half_adder cells and an OR for the carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  or u_or (co, c1, c2);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shifted LSB-first through one full adder,
// result returned on a valid/ready handshake after exactly WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic accept, last_bit, fa_s, fa_co;

  assign accept   = start_valid && (state_q == ST_IDLE);
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)                 state_d = ST_RUN;
      ST_RUN:  if (last_bit)               state_d = ST_DONE;
      ST_DONE: if (sum_ready)              state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == ST_IDLE);
    sum_valid   = (state_q == ST_DONE);
    busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  end

  // The result registers capture on the final RUN edge so sum/cout stay frozen
  // through DONE, IDLE and the next operation until it completes.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
      carry_d  = fa_co;
      cnt_d    = last_bit ? '0 : cnt_q + CW'(1);
      if (last_bit) begin
        sum_d  = sum_sh_d;
        cout_d = fa_co;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with an expected-result queue; WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid, start_ready, sum_valid, sum_ready, cin, cout, busy;
  logic [W-1:0] a, b, sum;

  logic w1_start_valid, w1_start_ready, w1_sum_valid, w1_sum_ready;
  logic w1_a, w1_b, w1_cin, w1_sum, w1_cout, w1_busy;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin),
    .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(w1_start_valid), .start_ready(w1_start_ready),
    .a(w1_a), .b(w1_b), .cin(w1_cin),
    .sum_valid(w1_sum_valid), .sum_ready(w1_sum_ready),
    .sum(w1_sum), .cout(w1_cout), .busy(w1_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one accept edge, then scramble the inputs.
  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    @(negedge clk);
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a = av; b = bv; cin = ci;
    sb.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci});
    @(negedge clk);
    start_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    chk("busy_run", 32'(busy), 32'd1);
    chk("start_ready_run", 32'(start_ready), 32'd0);
  endtask

  // Counts clock edges after the accept edge until sum_valid appears.
  task automatic wait_valid(input string tag);
    int j = 0;
    while (!sum_valid && j < 40) begin
      @(negedge clk);
      j++;
    end
    chk(tag, 32'(j), 32'(W));
  endtask

  task automatic take_result(input string tag);
    logic [W:0] e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    chk({tag, "_valid"}, 32'(sum_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(sum_valid), 32'd0);
    chk({tag, "_idle"}, 32'(start_ready), 32'd1);
  endtask

  initial begin
    int last_acc, n_acc, j;
    logic [W:0] e;

    rst_n = 1'b0;
    start_valid = 0; sum_ready = 0; a = '0; b = '0; cin = 0;
    w1_start_valid = 0; w1_sum_ready = 0; w1_a = 0; w1_b = 0; w1_cin = 0;
    #12;
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    drive_op(8'h3C, 8'h5A, 1'b0);
    wait_valid("lat_3c5a");
    take_result("add_3c5a");

    drive_op(8'hFF, 8'h01, 1'b0);
    wait_valid("lat_ff01");
    take_result("add_ff01");

    drive_op(8'hFF, 8'hFF, 1'b1);
    wait_valid("lat_ffff1");
    take_result("add_ffff1");

    // Stall in DONE with start_valid toggling: result must hold, nothing accepted.
    drive_op(8'hC3, 8'h81, 1'b0);
    wait_valid("lat_stall");
    e = (sb.size() != 0) ? sb[0] : '0;
    for (int i = 0; i < 5; i++) begin
      start_valid = ~start_valid;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(sum_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(e[W-1:0]));
      chk("stall_cout", 32'(cout), 32'(e[W]));
      chk("stall_no_accept", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    take_result("add_stall");

    // Reset during RUN cycle 3 discards the operation.
    drive_op(8'h77, 8'h11, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    chk("midrun_rst_start_ready", 32'(start_ready), 32'd1);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(8'h01, 8'h01, 1'b0);
    wait_valid("lat_0101");
    take_result("add_0101");

    // Back-to-back with both handshakes tied high.
    @(negedge clk);
    start_valid = 1'b1; sum_ready = 1'b1;
    a = 8'h10; b = 8'h20; cin = 1'b1;
    last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (start_ready && start_valid) begin
        sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        if (last_acc >= 0) chk("issue_interval", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        n_acc++;
      end
      if (sum_valid) begin
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("b2b_sum", 32'(sum), 32'(e[W-1:0]));
        chk("b2b_cout", 32'(cout), 32'(e[W]));
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 32'(n_acc), 32'd5);
    start_valid = 1'b0; sum_ready = 1'b0;
    j = 0;
    while (!sum_valid && j < 40) begin
      @(negedge clk);
      j++;
    end
    take_result("b2b_drain");

    // WIDTH=1 instance.
    @(negedge clk);
    chk("w1_start_ready", 32'(w1_start_ready), 32'd1);
    w1_start_valid = 1'b1; w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b1;
    @(negedge clk);
    w1_start_valid = 1'b0; w1_a = 1'b0; w1_b = 1'b0; w1_cin = 1'b0;
    j = 0;
    while (!w1_sum_valid && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("w1_latency", 32'(j), 32'd1);
    chk("w1_sum", 32'(w1_sum), 32'd1);
    chk("w1_cout", 32'(w1_cout), 32'd1);
    w1_sum_ready = 1'b1;
    @(negedge clk);
    w1_sum_ready = 1'b0;
    chk("w1_valid_drop", 32'(w1_sum_valid), 32'd0);
    chk("w1_idle", 32'(w1_start_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
